// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and defaults for the pipeline stall/flush sequencer
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2,
    ERR      = 2'd3
  } state_t;

  localparam int MEM_TIMEOUT_DEF = 16;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_en;
  } stage_ctrl_t;

  // Controls for a cycle with no memory stall: a branch squashes the
  // wrong-path ID instruction, so it overrides the load-use hazard.
  function automatic stage_ctrl_t run_ctrl(input logic br, input logic hz);
    stage_ctrl_t c;
    c.pc_en       = br | ~hz;
    c.if_id_en    = br | ~hz;
    c.if_id_flush = br;
    c.id_ex_en    = 1'b1;
    c.id_ex_flush = br | hz;
    c.ex_mem_en   = 1'b1;
    c.mem_wb_en   = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: increment-enabled counter that sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  // count up on inc_i, holding once the maximum value is reached
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (inc_i && cnt_q != '1) cnt_q <= cnt_q + W'(1);

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges load-use, branch and data-memory stalls into per-stage enables/flushes
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hdu_stall,
  input  logic             ex_branch_taken,
  input  logic             mem_access,
  input  logic             dmem_ack,
  input  logic             wb_halt,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  stage_ctrl_t ctl;

  // state and wait-cycle counter registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end

  // next state plus stage controls; everything stays zero while in reset or frozen
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    ctl      = '0;
    dmem_req = 1'b0;
    if (rst_n) begin
      case (state_q)
        RUN: begin
          dmem_req = mem_access;
          if (mem_access && !dmem_ack) begin
            state_d = MEM_WAIT;
            wait_d  = 8'd1;
          end else begin
            ctl     = run_ctrl(ex_branch_taken, hdu_stall);
            state_d = wb_halt ? HALT : RUN;
          end
        end
        MEM_WAIT: begin
          dmem_req = 1'b1;
          if (dmem_ack) begin
            ctl     = run_ctrl(ex_branch_taken, hdu_stall);
            state_d = RUN;
            wait_d  = '0;
          end else if (wait_q >= 8'(MEM_TIMEOUT)) state_d = ERR;
          else wait_d = wait_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign pc_en       = ctl.pc_en;
  assign if_id_en    = ctl.if_id_en;
  assign if_id_flush = ctl.if_id_flush;
  assign id_ex_en    = ctl.id_ex_en;
  assign id_ex_flush = ctl.id_ex_flush;
  assign ex_mem_en   = ctl.ex_mem_en;
  assign mem_wb_en   = ctl.mem_wb_en;
  assign halted      = state_q == HALT;
  assign err         = state_q == ERR;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i ((state_q == RUN || state_q == MEM_WAIT) && !pc_en),
    .cnt_o (stall_cnt)
  );

endmodule
